asrv32_fetch: RTL and testbench

Instruction fetch stage. It sits directly upstream of the decoder.
- Owns the program counter.
- Issues single-outstanding requests to instruction memory using a strobe/acknowledge handshake.
- Delivers the instruction word and its PC to the decode stage.
- Honours downstream stall and redirects (branch/jump/trap) from later stages.
- A one-entry skid buffer absorbs a response that returns while decode is stalled.

---
 rtl/asrv32_fetch_pkg.sv | 20 ++
 rtl/asrv32_fetch_skid.sv | 53 +++++
 rtl/asrv32_fetch.sv | 152 +++++++++++++++
 tb/tb_asrv32_fetch.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/asrv32_fetch_pkg.sv
// Shared fetch-stage definitions: PC width, NOP encoding and fetch FSM states.
package asrv32_fetch_pkg;

  localparam int unsigned PC_W = 32;

  localparam logic [6:0] OPCODE_OP_IMM = 7'b001_0011;
  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = {25'd0, OPCODE_OP_IMM};

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_FETCH = 2'd1,
    FETCH_DROP  = 2'd2
  } fetch_state_e;

  function automatic logic [PC_W-1:0] pc_incr(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction

endpackage

// File: rtl/asrv32_fetch_skid.sv
// One-entry skid buffer holding a fetched instruction and its PC while decode stalls.
module asrv32_fetch_skid
  import asrv32_fetch_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic            i_drain,
  input  logic            i_clear,
  input  logic [31:0]     i_inst,
  input  logic [PC_W-1:0] i_pc,
  output logic            o_valid,
  output logic [31:0]     o_inst,
  output logic [PC_W-1:0] o_pc
);

  logic            valid_q, valid_d;
  logic [31:0]     inst_q, inst_d;
  logic [PC_W-1:0] pc_q, pc_d;

  // Clear wins over load so a redirect can never leave a stale entry behind.
  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    if (i_clear) begin
      valid_d = 1'b0;
    end else if (i_load) begin
      valid_d = 1'b1;
      inst_d  = i_inst;
      pc_d    = i_pc;
    end else if (i_drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
    end
  end

  assign o_valid = valid_q;
  assign o_inst  = inst_q;
  assign o_pc    = pc_q;

endmodule

// File: rtl/asrv32_fetch.sv
// Instruction fetch stage: owns the PC, issues single-outstanding strobe/ack
// requests and hands instructions to decode, honouring stall and redirects.
module asrv32_fetch
  import asrv32_fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_iaddr,
  output logic        o_stb_inst,
  input  logic        i_ack_inst,
  input  logic [31:0] i_inst,
  input  logic        i_stall,
  input  logic        i_change_pc,
  input  logic [31:0] i_new_pc,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_ce
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] iaddr_q, iaddr_d;
  logic [PC_W-1:0] redirect_q, redirect_d;
  logic [31:0]     inst_q, inst_d;
  logic [PC_W-1:0] opc_q, opc_d;
  logic            ce_q, ce_d;

  logic            skid_load, skid_drain, skid_clear, skid_valid;
  logic [31:0]     skid_inst;
  logic [PC_W-1:0] skid_pc;

  logic [PC_W-1:0] target;
  logic            unused_new_pc_lo;

  assign target           = {i_new_pc[31:2], 2'b00};
  assign unused_new_pc_lo = ^i_new_pc[1:0];

  asrv32_fetch_skid u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (skid_load),
    .i_drain (skid_drain),
    .i_clear (skid_clear),
    .i_inst  (i_inst),
    .i_pc    (iaddr_q),
    .o_valid (skid_valid),
    .o_inst  (skid_inst),
    .o_pc    (skid_pc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    iaddr_d    = iaddr_q;
    redirect_d = redirect_q;
    inst_d     = inst_q;
    opc_d      = opc_q;
    ce_d       = i_stall ? ce_q : 1'b0;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    skid_clear = 1'b0;

    if (i_change_pc) begin
      ce_d       = 1'b0;
      skid_clear = 1'b1;
    end

    case (state_q)
      FETCH_IDLE: begin
        if (i_change_pc) begin
          pc_d    = target;
          iaddr_d = target;
          if (!i_stall) state_d = FETCH_FETCH;
        end else if (!i_stall) begin
          state_d = FETCH_FETCH;
          iaddr_d = pc_q;
          if (skid_valid) begin
            inst_d     = skid_inst;
            opc_d      = skid_pc;
            ce_d       = 1'b1;
            skid_drain = 1'b1;
          end
        end
      end

      FETCH_FETCH: begin
        if (i_change_pc) begin
          if (i_ack_inst) begin
            pc_d    = target;
            iaddr_d = target;
          end else begin
            redirect_d = target;
            state_d    = FETCH_DROP;
          end
        end else if (i_ack_inst) begin
          pc_d = pc_incr(pc_q);
          if (!i_stall) begin
            inst_d  = i_inst;
            opc_d   = iaddr_q;
            ce_d    = 1'b1;
            iaddr_d = pc_incr(pc_q);
          end else begin
            // o_iaddr keeps the captured address; IDLE reloads it from pc.
            skid_load = 1'b1;
            state_d   = FETCH_IDLE;
          end
        end
      end

      FETCH_DROP: begin
        if (i_ack_inst) begin
          pc_d    = i_change_pc ? target : redirect_q;
          iaddr_d = i_change_pc ? target : redirect_q;
          state_d = FETCH_FETCH;
        end else if (i_change_pc) begin
          redirect_d = target;
        end
      end

      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= FETCH_IDLE;
      pc_q       <= PC_RESET;
      iaddr_q    <= PC_RESET;
      redirect_q <= PC_RESET;
      inst_q     <= NOP_INST;
      opc_q      <= PC_RESET;
      ce_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      iaddr_q    <= iaddr_d;
      redirect_q <= redirect_d;
      inst_q     <= inst_d;
      opc_q      <= opc_d;
      ce_q       <= ce_d;
    end
  end

  assign o_stb_inst = (state_q != FETCH_IDLE);
  assign o_iaddr    = iaddr_q;
  assign o_inst     = inst_q;
  assign o_pc       = opc_q;
  assign o_ce       = ce_q;

endmodule

// File: tb/tb_asrv32_fetch.sv
// Directed bench for asrv32_fetch: zero-wait and delayed acks, stall/skid,
// redirects, PC wrap and asynchronous reset.
module tb_asrv32_fetch;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] o_iaddr;
  logic        o_stb_inst;
  logic        i_ack_inst;
  logic [31:0] i_inst;
  logic        i_stall;
  logic        i_change_pc;
  logic [31:0] i_new_pc;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        o_ce;

  logic zero_wait;
  logic ack_man;
  int   n_checks;
  int   n_fails;

  localparam logic [31:0] NOP = 32'h0000_0013;

  asrv32_fetch #(.PC_RESET(32'h0000_0000)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .o_iaddr     (o_iaddr),
    .o_stb_inst  (o_stb_inst),
    .i_ack_inst  (i_ack_inst),
    .i_inst      (i_inst),
    .i_stall     (i_stall),
    .i_change_pc (i_change_pc),
    .i_new_pc    (i_new_pc),
    .o_inst      (o_inst),
    .o_pc        (o_pc),
    .o_ce        (o_ce)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA5C3_0000 ^ a;
  endfunction

  // Memory model: responds with a word derived from the requested address.
  always_comb begin
    i_inst     = mem_word(o_iaddr);
    i_ack_inst = zero_wait ? o_stb_inst : ack_man;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fails     = 0;
    i_rst_n     = 1'b0;
    i_stall     = 1'b0;
    i_change_pc = 1'b0;
    i_new_pc    = '0;
    zero_wait   = 1'b1;
    ack_man     = 1'b0;
    tick();
    tick();
    chk("rst_iaddr", o_iaddr, 32'h0);
    chk("rst_stb", o_stb_inst, 1'b0);
    chk("rst_ce", o_ce, 1'b0);
    chk("rst_inst", o_inst, NOP);
    chk("rst_pc", o_pc, 32'h0);

    // Zero-wait memory from reset release.
    @(negedge i_clk) i_rst_n = 1'b1;
    tick();
    chk("zw1_iaddr", o_iaddr, 32'h0);
    chk("zw1_stb", o_stb_inst, 1'b1);
    chk("zw1_ce", o_ce, 1'b0);
    tick();
    chk("zw2_iaddr", o_iaddr, 32'h4);
    chk("zw2_ce", o_ce, 1'b1);
    chk("zw2_pc", o_pc, 32'h0);
    chk("zw2_inst", o_inst, mem_word(32'h0));
    tick();
    chk("zw3_iaddr", o_iaddr, 32'h8);
    chk("zw3_ce", o_ce, 1'b1);
    chk("zw3_pc", o_pc, 32'h4);
    chk("zw3_inst", o_inst, mem_word(32'h4));

    // Delayed ack: strobe and address held for 3 cycles.
    i_rst_n   = 1'b0;
    zero_wait = 1'b0;
    tick();
    tick();
    @(negedge i_clk) i_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dly_stb", o_stb_inst, 1'b1);
      chk("dly_iaddr", o_iaddr, 32'h0);
      chk("dly_ce", o_ce, 1'b0);
    end
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    chk("dly_ack_ce", o_ce, 1'b1);
    chk("dly_ack_pc", o_pc, 32'h0);
    chk("dly_ack_iaddr", o_iaddr, 32'h4);
    tick();
    chk("dly_ce_pulse", o_ce, 1'b0);
    chk("dly_wait_iaddr", o_iaddr, 32'h4);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    chk("dly_ack2_ce", o_ce, 1'b1);
    chk("dly_ack2_pc", o_pc, 32'h4);
    chk("dly_ack2_iaddr", o_iaddr, 32'h8);

    // Ack for addr 8 arrives during stall: goes to the skid buffer.
    i_stall = 1'b1;
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    chk("skid_inst_hold", o_inst, mem_word(32'h4));
    chk("skid_pc_hold", o_pc, 32'h4);
    chk("skid_ce_hold", o_ce, 1'b1);
    chk("skid_stb", o_stb_inst, 1'b0);
    tick();
    chk("skid_stall_pc", o_pc, 32'h4);
    chk("skid_stall_stb", o_stb_inst, 1'b0);
    i_stall = 1'b0;
    tick();
    chk("skid_rel_pc", o_pc, 32'h8);
    chk("skid_rel_inst", o_inst, mem_word(32'h8));
    chk("skid_rel_ce", o_ce, 1'b1);
    chk("skid_next_iaddr", o_iaddr, 32'hC);
    chk("skid_next_stb", o_stb_inst, 1'b1);

    // Redirect while waiting on addr 4.
    i_rst_n = 1'b0;
    tick();
    @(negedge i_clk) i_rst_n = 1'b1;
    tick();
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    chk("rd_first_pc", o_pc, 32'h0);
    chk("rd_wait_iaddr", o_iaddr, 32'h4);
    i_change_pc = 1'b1;
    i_new_pc    = 32'h100;
    tick();
    i_change_pc = 1'b0;
    chk("rd_drop_ce", o_ce, 1'b0);
    chk("rd_drop_stb", o_stb_inst, 1'b1);
    chk("rd_drop_iaddr", o_iaddr, 32'h4);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    chk("rd_new_iaddr", o_iaddr, 32'h100);
    chk("rd_no_ce4", o_ce, 1'b0);
    tick();
    chk("rd_no_ce4_b", o_ce, 1'b0);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    chk("rd_tgt_ce", o_ce, 1'b1);
    chk("rd_tgt_pc", o_pc, 32'h100);
    chk("rd_tgt_iaddr", o_iaddr, 32'h104);

    // Redirect coincident with ack and stall; unaligned target.
    i_stall     = 1'b1;
    ack_man     = 1'b1;
    i_change_pc = 1'b1;
    i_new_pc    = 32'h103;
    tick();
    i_change_pc = 1'b0;
    ack_man     = 1'b0;
    chk("rca_iaddr", o_iaddr, 32'h100);
    chk("rca_ce", o_ce, 1'b0);
    chk("rca_stb", o_stb_inst, 1'b1);
    i_stall = 1'b0;
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    chk("rca_deliv_pc", o_pc, 32'h100);
    chk("rca_deliv_ce", o_ce, 1'b1);
    chk("rca_next_iaddr", o_iaddr, 32'h104);

    // PC wrap with zero-wait memory.
    zero_wait   = 1'b1;
    i_change_pc = 1'b1;
    i_new_pc    = 32'hFFFF_FFFC;
    tick();
    i_change_pc = 1'b0;
    chk("wrap_iaddr0", o_iaddr, 32'hFFFF_FFFC);
    chk("wrap_ce0", o_ce, 1'b0);
    tick();
    chk("wrap_iaddr1", o_iaddr, 32'h0);
    chk("wrap_pc1", o_pc, 32'hFFFF_FFFC);
    chk("wrap_ce1", o_ce, 1'b1);
    tick();
    chk("wrap_iaddr2", o_iaddr, 32'h4);
    chk("wrap_pc2", o_pc, 32'h0);

    // Asynchronous reset mid-cycle while a request is outstanding.
    zero_wait = 1'b0;
    tick();
    chk("arst_pre_stb", o_stb_inst, 1'b1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_stb", o_stb_inst, 1'b0);
    chk("arst_inst", o_inst, NOP);
    chk("arst_ce", o_ce, 1'b0);
    chk("arst_iaddr", o_iaddr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
